multicycle_controller: RTL and testbench

Control FSM for the multicycle variant of the RISC-V core. It replaces the per-instruction combinational decode with a state machine that steps the shared datapath through fetch, decode, execute, memory and writeback. One ALU, one unified memory port and one register file are time-shared across cycles. It drives the datapath enables and muxes, and it stalls on a memory-ready handshake.

---
 rtl/multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Control FSM for the multicycle RISC-V core. It steps the shared datapath
// (one ALU, one unified memory port, one register file) through fetch,
// decode, execute, memory and writeback, and stalls on mem_ready in the
// states that access memory.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : unknown opcodes enter TRAP (halts until reset); the `illegal`
//               port exists and is high in TRAP.
//   undefined : unknown opcodes fall back to FETCH (2-cycle NOP); no TRAP
//               state and no `illegal` port.
//
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous active-high reset, forces FETCH
//   op         opcode from IR
//   funct3     funct3 from IR
//   Zero       ALU result == 0
//   ALUR31     ALU result bit 31
//   mem_ready  memory completes the current access this cycle
//   PCWrite    PC load enable
//   AdrSrc     memory address select (0 PC, 1 ALUOut)
//   MemWrite   memory write strobe
//   IRWrite    IR / OldPC load enable
//   RegWrite   register-file write enable
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA    00 PC, 01 OldPC, 10 RD1
//   ALUSrcB    00 RD2, 01 ImmExt, 10 constant 4
//   ALUOp      00 add, 01 subtract, 10 funct-decoded
//   ImmSrc     000 I, 001 S, 010 B, 011 J, 100 U (from op)
//   state      current state for debug
//   illegal    high in TRAP (macro builds only)
//
// state    | meaning
// ---------+---------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC + imm, dispatch on op
// MEMADR   | ALUOut <= RD1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write load data to rd
// MEMWRITE | write RD2 to memory at ALUOut
// EXECUTER | ALUOut <= RD1 op RD2
// EXECUTEI | ALUOut <= RD1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare RD1/RD2, PC <= ALUOut if taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// JALR     | PC <= RD1 + imm
// LINKWB   | rd <= OldPC+4
// LUI      | rd <= ImmExt
// TRAP     | illegal opcode, halted until reset

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] state
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINKWB   = 4'd12,
        S_LUI      = 4'd13
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd14
`endif
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    logic illegal_d;

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal_d = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // PC and IR load only on the cycle the fetch completes.
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_IALU:           state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    3'b101:  PCWrite = ~ALUR31;
                    default: PCWrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_LINKWB;
            end
            S_LINKWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_d = 1'b1;
                state_d   = S_TRAP;
            end
`endif
            // Unused encodings recover to FETCH with all enables low.
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = illegal_d;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller. Each instruction is
// walked cycle by cycle against a hand-written expected state sequence, and
// every output is compared against a per-state table of expected values.
// Define MC_ILLEGAL_TRAP_EN to exercise the TRAP build.

module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       ALUR31;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .Zero      (Zero),
        .ALUR31    (ALUR31),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .state     (state)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // {AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    function automatic logic [12:0] exp_outs(input int s);
        case (s)
            0:  return {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
            1:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
            2:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
            3:  return {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
            4:  return {1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
            5:  return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
            6:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
            7:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
            8:  return {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            9:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
            10: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
            11: return {1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00};
            12: return {1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b10, 2'b00};
            13: return {1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
            default: return 13'd0;
        endcase
    endfunction

    // Walks n cycles starting at a negedge. seq holds the expected state per
    // cycle (nibble i = cycle i), rdy the mem_ready value driven per cycle,
    // bpc the expected PCWrite in BRANCH, imm the expected ImmSrc.
    task automatic run_seq(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input logic r31, input int n,
                           input logic [31:0] seq, input logic [7:0] rdy,
                           input logic bpc, input logic [2:0] imm);
        op     = o;
        funct3 = f3;
        Zero   = z;
        ALUR31 = r31;
        for (int i = 0; i < n; i++) begin
            logic [3:0] es;
            logic       epc;
            es = seq[4*i +: 4];
            mem_ready = rdy[i];
            #1;
            case (es)
                4'd0:         epc = rdy[i];
                4'd9:         epc = bpc;
                4'd10, 4'd11: epc = 1'b1;
                default:      epc = 1'b0;
            endcase
            check($sformatf("%s c%0d state", name, i), state, es);
            check($sformatf("%s c%0d outs", name, i),
                  {AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp},
                  exp_outs(int'(es)));
            check($sformatf("%s c%0d PCWrite", name, i), PCWrite, epc);
            check($sformatf("%s c%0d IRWrite", name, i), IRWrite, (es == 4'd0) ? rdy[i] : 1'b0);
            check($sformatf("%s c%0d ImmSrc", name, i), ImmSrc, imm);
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = 7'b0000011;
        funct3    = 3'b010;
        Zero      = 1'b0;
        ALUR31    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst state", state, 0);
        check("rst outs", {AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp},
              {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00});
        check("rst PCWrite", PCWrite, 1);
        check("rst IRWrite", IRWrite, 1);
        mem_ready = 1'b0;
        #1;
        check("rst PCWrite rdy0", PCWrite, 0);
        check("rst IRWrite rdy0", IRWrite, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        check("rst illegal", illegal, 0);
`endif
        mem_ready = 1'b1;
        reset     = 1'b0;

        // lw with two MEMREAD wait states: 0,1,2,3,3,3,4
        run_seq("lw",      7'b0000011, 3'b010, 0, 0, 7, 32'h0433_3210, 8'hE7, 0, 3'b000);
        // sw zero wait: 0,1,2,5
        run_seq("sw",      7'b0100011, 3'b010, 0, 0, 4, 32'h0000_5210, 8'hFF, 0, 3'b001);
        // sw with one MEMWRITE wait: 0,1,2,5,5
        run_seq("sw_wait", 7'b0100011, 3'b010, 0, 0, 5, 32'h0005_5210, 8'hF7, 0, 3'b001);
        // R-type with one FETCH wait: 0,0,1,6,8
        run_seq("rtype",   7'b0110011, 3'b000, 0, 0, 5, 32'h0008_6100, 8'hFE, 0, 3'b000);
        run_seq("ialu",    7'b0010011, 3'b000, 0, 0, 4, 32'h0000_8710, 8'hFF, 0, 3'b000);
        run_seq("beq_t",   7'b1100011, 3'b000, 1, 0, 3, 32'h0000_0910, 8'hFF, 1, 3'b010);
        run_seq("beq_n",   7'b1100011, 3'b000, 0, 0, 3, 32'h0000_0910, 8'hFF, 0, 3'b010);
        run_seq("bne_z",   7'b1100011, 3'b001, 1, 0, 3, 32'h0000_0910, 8'hFF, 0, 3'b010);
        run_seq("bne_nz",  7'b1100011, 3'b001, 0, 0, 3, 32'h0000_0910, 8'hFF, 1, 3'b010);
        run_seq("bge_t",   7'b1100011, 3'b101, 0, 0, 3, 32'h0000_0910, 8'hFF, 1, 3'b010);
        run_seq("bge_n",   7'b1100011, 3'b101, 0, 1, 3, 32'h0000_0910, 8'hFF, 0, 3'b010);
        run_seq("blt",     7'b1100011, 3'b100, 1, 0, 3, 32'h0000_0910, 8'hFF, 0, 3'b010);
        run_seq("jal",     7'b1101111, 3'b000, 0, 0, 4, 32'h0000_8A10, 8'hFF, 0, 3'b011);
        run_seq("jalr",    7'b1100111, 3'b000, 0, 0, 4, 32'h0000_CB10, 8'hFF, 0, 3'b000);
        // mem_ready low in DECODE must be ignored
        run_seq("lui",     7'b0110111, 3'b000, 0, 0, 3, 32'h0000_0D10, 8'hFD, 0, 3'b100);
        run_seq("auipc",   7'b0010111, 3'b000, 0, 0, 3, 32'h0000_0810, 8'hFF, 0, 3'b100);

        // Reset mid-store: MemWrite must drop without a clock edge.
        run_seq("sw_rst",  7'b0100011, 3'b010, 0, 0, 3, 32'h0000_0210, 8'hFF, 0, 3'b001);
        mem_ready = 1'b0;
        #1;
        check("sw_rst pre state", state, 5);
        check("sw_rst pre MemWrite", MemWrite, 1);
        #1;
        reset = 1'b1;
        #1;
        check("sw_rst async state", state, 0);
        check("sw_rst async MemWrite", MemWrite, 0);
        @(negedge clk);
        mem_ready = 1'b1;
        reset     = 1'b0;

`ifdef MC_ILLEGAL_TRAP_EN
        run_seq("illegal", 7'b0000000, 3'b000, 0, 0, 2, 32'h0000_0010, 8'hFF, 0, 3'b000);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("trap c%0d state", k), state, 14);
            check($sformatf("trap c%0d illegal", k), illegal, 1);
            check($sformatf("trap c%0d enables", k),
                  {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
            @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        check("trap rst state", state, 0);
        check("trap rst illegal", illegal, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        run_seq("illegal", 7'b0000000, 3'b000, 0, 0, 2, 32'h0000_0010, 8'hFF, 0, 3'b000);
`endif
        // Back in FETCH after the unknown op (or after reset from TRAP).
        run_seq("post",    7'b0010111, 3'b000, 0, 0, 3, 32'h0000_0810, 8'hFF, 0, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
